// File: rtl/io_bus_responder_pkg.sv
// Register map and status-bit layout of the CPU IO_BUS responder.
// Shared with the CPU-side address decode and software tests.
package io_bus_responder_pkg;

   localparam logic [15:0] BASE_ADDR_DEF = 16'h7F00;
   localparam int unsigned DATA_W        = 32;

   localparam logic [7:0] OFF_OUT_DATA = 8'h00;
   localparam logic [7:0] OFF_IN_DATA  = 8'h04;
   localparam logic [7:0] OFF_STATUS   = 8'h08;
   localparam logic [7:0] OFF_LED      = 8'h0C;
   localparam logic [7:0] OFF_SW       = 8'h10;
   localparam logic [7:0] OFF_BTN_EDGE = 8'h14;
   localparam logic [7:0] OFF_CYCLE    = 8'h18;

   localparam int unsigned STAT_OUT_EMPTY = 0;
   localparam int unsigned STAT_IN_VALID  = 1;
   localparam int unsigned STAT_OVERRUN   = 2;

   // Encoding equals the word index of the register within the map.
   typedef enum logic [2:0] {
      REG_OUT_DATA = 3'd0,
      REG_IN_DATA  = 3'd1,
      REG_STATUS   = 3'd2,
      REG_LED      = 3'd3,
      REG_SW       = 3'd4,
      REG_BTN_EDGE = 3'd5,
      REG_CYCLE    = 3'd6,
      REG_NONE     = 3'd7
   } reg_sel_e;

   function automatic reg_sel_e decode_reg(input logic [13:0] word_off);
      if (word_off[13:3] != 11'd0) return REG_NONE;
      return reg_sel_e'(word_off[2:0]);
   endfunction

endpackage

// File: rtl/io_bus_responder_edge_sync.sv
// Multi-flop synchroniser for asynchronous board inputs with a history
// flop for rising-edge detection.
module io_bus_responder_edge_sync #(
   parameter int unsigned W      = 1,
   parameter int unsigned STAGES = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] level,
   output logic [W-1:0] rise_c
);

   logic [W-1:0] stage [STAGES];
   logic [W-1:0] hist;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
         hist <= '0;
      end else begin
         stage[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
         hist <= stage[STAGES-1];
      end
   end

   always_comb begin
      level  = stage[STAGES-1];
      rise_c = stage[STAGES-1] & ~hist;
   end

endmodule

// File: rtl/io_bus_responder.sv
// Memory-mapped responder for the CPU IO_BUS: mailboxes toward the panel/debug
// unit, LEDs, synchronised switches/buttons and a free-running cycle counter.
module io_bus_responder
   import io_bus_responder_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR   = BASE_ADDR_DEF,
   parameter int unsigned LED_W       = 16,
   parameter int unsigned SW_W        = 16,
   parameter int unsigned BTN_W       = 5,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       io_addr,
   input  logic [31:0]       io_dout,
   input  logic              io_we,
   input  logic              io_rd,
   output logic [31:0]       io_din,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ack,
   input  logic [31:0]       in_data,
   input  logic              in_push,
   output logic [LED_W-1:0]  led,
   input  logic [SW_W-1:0]   sw,
   input  logic [BTN_W-1:0]  btn
);

   logic [13:0]       word_off;
   logic [1:0]        addr_lsb_unused;
   reg_sel_e          sel;
   logic [31:0]       in_data_reg;
   logic              in_valid;
   logic              overrun;
   logic [BTN_W-1:0]  btn_edge;
   logic [31:0]       cycle;
   logic [SW_W-1:0]   sw_sync;
   logic [SW_W-1:0]   sw_rise_unused;
   logic [BTN_W-1:0]  btn_sync_unused;
   logic [BTN_W-1:0]  btn_rise;

   logic wr_out, wr_status, wr_led;
   logic rd_in, rd_btn;
   logic ov_set, ov_clr;
   logic [DATA_W-1:0] status;

   io_bus_responder_edge_sync #(.W(SW_W), .STAGES(SYNC_STAGES)) u_sw_sync (
      .clk    (clk),
      .rst    (rst),
      .d      (sw),
      .level  (sw_sync),
      .rise_c (sw_rise_unused)
   );

   io_bus_responder_edge_sync #(.W(BTN_W), .STAGES(SYNC_STAGES)) u_btn_sync (
      .clk    (clk),
      .rst    (rst),
      .d      (btn),
      .level  (btn_sync_unused),
      .rise_c (btn_rise)
   );

   // Word-granular decode; the byte lane bits play no part.
   always_comb begin
      addr_lsb_unused = io_addr[1:0];
      word_off        = io_addr[15:2] - BASE_ADDR[15:2];
      sel             = decode_reg(word_off);
   end

   // A simultaneous write takes the access; read side effects are dropped.
   always_comb begin
      wr_out    = io_we && (sel == REG_OUT_DATA);
      wr_status = io_we && (sel == REG_STATUS);
      wr_led    = io_we && (sel == REG_LED);
      rd_in     = io_rd && !io_we && (sel == REG_IN_DATA);
      rd_btn    = io_rd && !io_we && (sel == REG_BTN_EDGE);
      ov_set    = in_push && in_valid && !rd_in;
      ov_clr    = wr_status && io_dout[STAT_OVERRUN];
   end

   always_comb begin
      status                 = '0;
      status[STAT_OUT_EMPTY] = ~out_valid;
      status[STAT_IN_VALID]  = in_valid;
      status[STAT_OVERRUN]   = overrun;
   end

   always_comb begin
      io_din = '0;
      if (io_rd) begin
         case (sel)
            REG_OUT_DATA: io_din = out_data;
            REG_IN_DATA:  io_din = in_data_reg;
            REG_STATUS:   io_din = status;
            REG_LED:      io_din = 32'(led);
            REG_SW:       io_din = 32'(sw_sync);
            REG_BTN_EDGE: io_din = 32'(btn_edge);
            REG_CYCLE:    io_din = cycle;
            default:      io_din = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data    <= '0;
         out_valid   <= 1'b0;
         in_data_reg <= '0;
         in_valid    <= 1'b0;
         overrun     <= 1'b0;
         led         <= '0;
         btn_edge    <= '0;
         cycle       <= '0;
      end else begin
         // A CPU write in the ack cycle re-arms the mailbox with the new word.
         if (wr_out) begin
            out_data  <= io_dout;
            out_valid <= 1'b1;
         end else if (out_ack && out_valid) begin
            out_valid <= 1'b0;
         end

         if (in_push) begin
            in_data_reg <= in_data;
            in_valid    <= 1'b1;
         end else if (rd_in) begin
            in_valid <= 1'b0;
         end

         overrun <= ov_set | (overrun & ~ov_clr);

         if (wr_led) led <= io_dout[LED_W-1:0];

         btn_edge <= btn_rise | (rd_btn ? '0 : btn_edge);
         cycle    <= cycle + 32'd1;
      end
   end

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: directed register-map scenarios followed by
// randomized bus/handshake traffic against a behavioural model.
module tb_io_bus_responder;

   localparam logic [15:0] BASE = 16'h7F00;
   localparam int unsigned LW   = 16;
   localparam int unsigned SWW  = 16;
   localparam int unsigned BW   = 5;
   localparam int unsigned SS   = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [15:0]     io_addr;
   logic [31:0]     io_dout;
   logic            io_we, io_rd;
   logic [31:0]     io_din;
   logic [31:0]     out_data;
   logic            out_valid;
   logic            out_ack;
   logic [31:0]     in_data;
   logic            in_push;
   logic [LW-1:0]   led;
   logic [SWW-1:0]  sw;
   logic [BW-1:0]   btn;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   logic [31:0]    m_out_data, m_in_data, m_cycle;
   logic           m_out_valid, m_in_valid, m_overrun;
   logic [LW-1:0]  m_led;
   logic [BW-1:0]  m_btn_edge;
   logic [SWW-1:0] sw_q[$];   // pin history, newest first, one entry per edge
   logic [BW-1:0]  btn_q[$];

   always #5 clk = ~clk;

   io_bus_responder #(
      .BASE_ADDR(BASE), .LED_W(LW), .SW_W(SWW), .BTN_W(BW), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk), .rst(rst), .io_addr(io_addr), .io_dout(io_dout), .io_we(io_we),
      .io_rd(io_rd), .io_din(io_din), .out_data(out_data), .out_valid(out_valid),
      .out_ack(out_ack), .in_data(in_data), .in_push(in_push), .led(led),
      .sw(sw), .btn(btn)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic int reg_index(input logic [15:0] a);
      logic [15:0] o;
      o = (a & 16'hFFFC) - BASE;
      if (o > 16'h0018) return -1;
      return int'(o >> 2);
   endfunction

   function automatic logic [31:0] model_read();
      if (!io_rd) return 32'h0;
      case (reg_index(io_addr))
         0: return m_out_data;
         1: return m_in_data;
         2: return {29'h0, m_overrun, m_in_valid, ~m_out_valid};
         3: return 32'(m_led);
         4: return 32'(sw_q[SS-1]);
         5: return 32'(m_btn_edge);
         6: return m_cycle;
         default: return 32'h0;
      endcase
   endfunction

   // Applies one rising edge to the model using the inputs held across it.
   task automatic model_update();
      int            idx;
      bit            wr, rd;
      logic [BW-1:0] rise;
      idx  = reg_index(io_addr);
      wr   = io_we;
      rd   = io_rd && !io_we;
      rise = btn_q[SS-1] & ~btn_q[SS];
      if (rst) begin
         m_out_data = 0; m_out_valid = 0; m_in_data = 0; m_in_valid = 0;
         m_overrun = 0; m_led = 0; m_btn_edge = 0; m_cycle = 0;
         sw_q.push_front('0);
         btn_q.push_front('0);
      end else begin
         if (wr && idx == 0) begin
            m_out_data = io_dout;
            m_out_valid = 1;
         end else if (out_ack && m_out_valid) begin
            m_out_valid = 0;
         end
         if (in_push && m_in_valid && !(rd && idx == 1)) m_overrun = 1;
         else if (wr && idx == 2 && io_dout[2]) m_overrun = 0;
         if (in_push) begin
            m_in_data = in_data;
            m_in_valid = 1;
         end else if (rd && idx == 1) begin
            m_in_valid = 0;
         end
         if (wr && idx == 3) m_led = io_dout[LW-1:0];
         m_btn_edge = rise | ((rd && idx == 5) ? '0 : m_btn_edge);
         m_cycle = m_cycle + 1;
         sw_q.push_front(sw);
         btn_q.push_front(btn);
      end
      void'(sw_q.pop_back());
      void'(btn_q.pop_back());
   endtask

   task automatic drive_idle();
      io_we = 0; io_rd = 0; out_ack = 0; in_push = 0;
      io_addr = BASE; io_dout = 0; in_data = 0;
   endtask

   task automatic half();
      #4;
   endtask

   task automatic close();
      check_val("io_din", io_din, model_read());
      check_val("out_data", out_data, m_out_data);
      check_val("out_valid", 32'(out_valid), 32'(m_out_valid));
      check_val("led", 32'(led), 32'(m_led));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic tick();
      half();
      close();
   endtask

   task automatic rd_expect(input logic [15:0] a, input logic [31:0] exp, input string tag);
      io_addr = a;
      io_rd = 1;
      half();
      check_val(tag, io_din, exp);
      close();
      io_rd = 0;
   endtask

   task automatic wr_cycle(input logic [15:0] a, input logic [31:0] d);
      io_addr = a; io_dout = d; io_we = 1;
      tick();
      drive_idle();
   endtask

   task automatic push_cycle(input logic [31:0] d);
      in_data = d; in_push = 1;
      tick();
      drive_idle();
   endtask

   initial begin
      rst = 1; sw = 0; btn = 0;
      drive_idle();
      m_out_data = 0; m_out_valid = 0; m_in_data = 0; m_in_valid = 0;
      m_overrun = 0; m_led = 0; m_btn_edge = 0; m_cycle = 0;
      for (int i = 0; i <= int'(SS); i++) begin
         sw_q.push_front('0);
         btn_q.push_front('0);
      end
      @(posedge clk);
      model_update();
      #1;
      tick();
      rst = 0;

      // Reset state and cycle counter
      io_addr = 16'h7F08; io_rd = 1;
      half();
      check_val("led_rst", 32'(led), 32'h0);
      check_val("ovalid_rst", 32'(out_valid), 32'h0);
      check_val("status_rst", io_din, 32'h1);
      close();
      drive_idle();
      repeat (4) tick();
      rd_expect(16'h7F18, 32'd5, "cycle_5");

      // Output mailbox write and ack
      wr_cycle(16'h7F00, 32'hDEAD_BEEF);
      io_addr = 16'h7F08; io_rd = 1;
      half();
      check_val("status_full", io_din, 32'h0);
      check_val("out_word", out_data, 32'hDEAD_BEEF);
      check_val("ovalid_set", 32'(out_valid), 32'h1);
      close();
      drive_idle();
      out_ack = 1;
      tick();
      drive_idle();
      rd_expect(16'h7F08, 32'h1, "status_acked");

      // Write racing an ack keeps the mailbox full with the new word
      wr_cycle(16'h7F00, 32'h1111_2222);
      io_addr = 16'h7F00; io_dout = 32'h3333_4444; io_we = 1; out_ack = 1;
      tick();
      drive_idle();
      half();
      check_val("race_valid", 32'(out_valid), 32'h1);
      check_val("race_word", out_data, 32'h3333_4444);
      close();
      wr_cycle(16'h7F40, 32'hFFFF_FFFF);
      half();
      check_val("unmapped_word", out_data, 32'h3333_4444);
      check_val("unmapped_led", 32'(led), 32'h0);
      close();

      // Input mailbox overrun and clear
      push_cycle(32'h1234);
      push_cycle(32'h5678);
      rd_expect(16'h7F08, 32'h6, "status_overrun");
      wr_cycle(16'h7F08, 32'h4);
      rd_expect(16'h7F08, 32'h2, "status_ov_clr");
      rd_expect(16'h7F04, 32'h5678, "in_data_last");
      rd_expect(16'h7F08, 32'h0, "status_in_read");

      // Push in the same cycle as a read of the previous word
      push_cycle(32'h1111);
      io_addr = 16'h7F04; io_rd = 1; in_push = 1; in_data = 32'hAAAA;
      half();
      check_val("in_data_prior", io_din, 32'h1111);
      close();
      drive_idle();
      rd_expect(16'h7F08, 32'h2, "status_push_rd");
      rd_expect(16'h7F06, 32'hAAAA, "in_data_new");

      // Switch synchroniser
      sw = 16'hA5C3;
      repeat (SS) tick();
      rd_expect(16'h7F10, 32'hA5C3, "sw_sync");

      // Button edge latency, read-clear, no re-trigger while held
      btn = 5'b00100;
      for (int i = 0; i < int'(SS) + 1; i++) rd_expect(16'h7F14, 32'h0, "btn_latency");
      rd_expect(16'h7F14, 32'h4, "btn_edge");
      rd_expect(16'h7F14, 32'h0, "btn_clr");
      repeat (5) tick();
      rd_expect(16'h7F14, 32'h0, "btn_held");
      btn = 5'b00000;
      repeat (4) tick();
      rd_expect(16'h7F14, 32'h0, "btn_release");
      btn = 5'b00100;
      repeat (SS + 1) tick();
      rd_expect(16'h7F14, 32'h4, "btn_repress");

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         int unsigned pick;
         pick = $urandom_range(0, 9);
         if (pick < 8) io_addr = BASE + 16'(pick * 4) + 16'($urandom_range(0, 3));
         else if (pick == 8) io_addr = 16'h7F40;
         else io_addr = 16'($urandom);
         io_dout = $urandom;
         io_we   = ($urandom_range(0, 3) == 0);
         io_rd   = ($urandom_range(0, 1) == 1);
         out_ack = ($urandom_range(0, 2) == 0);
         in_push = ($urandom_range(0, 3) == 0);
         in_data = $urandom;
         if ($urandom_range(0, 7) == 0) sw = SWW'($urandom);
         if ($urandom_range(0, 3) == 0) btn = BW'($urandom);
         rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 0;
      drive_idle();
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
